// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the cpu load/store
// path and a debug/loader port, round-robin, one access at a time.
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_done,
   output logic              cpu_err,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_done,
   output logic              dbg_err,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [3:0] LAT_C = 4'(LAT);

   state_t            state_q, state_d;
   logic              own_q, own_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              cpu_done_q, cpu_done_d;
   logic              dbg_done_q, dbg_done_d;
   logic              cpu_err_q, cpu_err_d;
   logic              dbg_err_q, dbg_err_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

   logic              idle;
   logic              acc;
   logic              acc_we;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;

   // Grant only in IDLE; on a tie the requester that did not own last wins
   always_comb begin
      idle      = (state_q == S_IDLE) && !rst;
      cpu_gnt   = idle && cpu_req && (!dbg_req || own_q);
      dbg_gnt   = idle && dbg_req && (!cpu_req || !own_q);
      acc       = cpu_gnt || dbg_gnt;
      acc_we    = dbg_gnt ? dbg_we : cpu_we;
      acc_addr  = dbg_gnt ? dbg_addr : cpu_addr;
      acc_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
   end

   // Next-state and registered-output computation for the access sequencer
   always_comb begin
      state_d     = state_q;
      own_d       = own_q;
      cnt_d       = cnt_q;
      mem_en_d    = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_done_d  = 1'b0;
      dbg_done_d  = 1'b0;
      cpu_err_d   = 1'b0;
      dbg_err_d   = 1'b0;
      cpu_rdata_d = '0;
      dbg_rdata_d = '0;
      unique case (state_q)
         S_IDLE: begin
            if (acc) begin
               own_d = dbg_gnt;
               if (acc_addr[1:0] != 2'b00) begin
                  state_d    = S_DONE;
                  cpu_done_d = cpu_gnt;
                  dbg_done_d = dbg_gnt;
                  cpu_err_d  = cpu_gnt;
                  dbg_err_d  = dbg_gnt;
               end else begin
                  state_d     = S_ISSUE;
                  mem_en_d    = 1'b1;
                  mem_we_d    = acc_we;
                  mem_addr_d  = acc_addr;
                  mem_wdata_d = acc_wdata;
               end
            end
         end
         S_ISSUE: begin
            cnt_d   = LAT_C;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d    = S_DONE;
               cpu_done_d = !own_q;
               dbg_done_d = own_q;
               if (!mem_we_q) begin
                  cpu_rdata_d = own_q ? '0 : mem_rdata;
                  dbg_rdata_d = own_q ? mem_rdata : '0;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any access in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         own_q       <= 1'b1;
         cnt_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_done_q  <= 1'b0;
         dbg_done_q  <= 1'b0;
         cpu_err_q   <= 1'b0;
         dbg_err_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         own_q       <= own_d;
         cnt_q       <= cnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_done_q  <= cpu_done_d;
         dbg_done_q  <= dbg_done_d;
         cpu_err_q   <= cpu_err_d;
         dbg_err_q   <= dbg_err_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_done  = cpu_done_q;
   assign dbg_done  = dbg_done_q;
   assign cpu_err   = cpu_err_q;
   assign dbg_err   = dbg_err_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table, directed and random checks of dmem_arbiter
// on a LAT=1 and a LAT=3 instance sharing the requester inputs.
module tb_dmem_arbiter;

   localparam int NI = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic        dbg_req = 1'b0, dbg_we = 1'b0;
   logic [31:0] dbg_addr = '0, dbg_wdata = '0;

   logic        cpu_gnt [NI];
   logic        cpu_done [NI];
   logic        cpu_err [NI];
   logic [31:0] cpu_rdata [NI];
   logic        dbg_gnt [NI];
   logic        dbg_done [NI];
   logic        dbg_err [NI];
   logic [31:0] dbg_rdata [NI];
   logic        mem_en [NI];
   logic        mem_we [NI];
   logic [31:0] mem_addr [NI];
   logic [31:0] mem_wdata [NI];
   logic [31:0] mem_rdata [NI];

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Cycle index: cycle k runs from posedge k to posedge k+1
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(input int i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %08h expected %08h",
                  nm, cyc, got, exp);
      end
   endtask

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int L = (g == 0) ? 1 : 3;

      dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(L)) u_dut (
         .clk      (clk),
         .rst      (rst),
         .cpu_req  (cpu_req),
         .cpu_we   (cpu_we),
         .cpu_addr (cpu_addr),
         .cpu_wdata(cpu_wdata),
         .cpu_gnt  (cpu_gnt[g]),
         .cpu_done (cpu_done[g]),
         .cpu_err  (cpu_err[g]),
         .cpu_rdata(cpu_rdata[g]),
         .dbg_req  (dbg_req),
         .dbg_we   (dbg_we),
         .dbg_addr (dbg_addr),
         .dbg_wdata(dbg_wdata),
         .dbg_gnt  (dbg_gnt[g]),
         .dbg_done (dbg_done[g]),
         .dbg_err  (dbg_err[g]),
         .dbg_rdata(dbg_rdata[g]),
         .mem_en   (mem_en[g]),
         .mem_we   (mem_we[g]),
         .mem_addr (mem_addr[g]),
         .mem_wdata(mem_wdata[g]),
         .mem_rdata(mem_rdata[g])
      );

      // Memory device: read data is valid only LAT cycles after mem_en
      logic [31:0] dev [64];
      int          rd_due = -1;
      logic [31:0] rd_dat = '0;

      initial for (int i = 0; i < 64; i++) dev[i] = init_word(i);

      always @(posedge clk)
         if (mem_en[g]) begin
            if (mem_we[g]) dev[mem_addr[g][7:2]] <= mem_wdata[g];
            else begin
               rd_due <= cyc + L;
               rd_dat <= dev[mem_addr[g][7:2]];
            end
         end

      assign mem_rdata[g] = (cyc == rd_due) ? rd_dat
                                            : (32'hA5A5_0000 ^ 32'(cyc));

      // Reference: schedule of issue/done cycles plus a word memory
      int          free_at = 0, iss_c = -1, don_c = -1;
      logic        m_last = 1'b1, m_own = 1'b0, m_err = 1'b0, m_we = 1'b0;
      logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
      logic [31:0] refm [64];
      logic        m_gc, m_gd, a_we;
      logic [31:0] a_addr, a_wdata;

      initial for (int i = 0; i < 64; i++) refm[i] = init_word(i);

      always_comb begin
         m_gc = (rst == 1'b0) && (cyc >= free_at) && cpu_req &&
                (!dbg_req || m_last);
         m_gd = (rst == 1'b0) && (cyc >= free_at) && dbg_req &&
                (!cpu_req || !m_last);
         a_we    = m_gd ? dbg_we : cpu_we;
         a_addr  = m_gd ? dbg_addr : cpu_addr;
         a_wdata = m_gd ? dbg_wdata : cpu_wdata;
      end

      always @(posedge clk) begin
         if (rst) begin
            free_at <= cyc + 1;
            iss_c   <= -1;
            don_c   <= -1;
            m_last  <= 1'b1;
         end else if (m_gc || m_gd) begin
            m_own   <= m_gd;
            m_last  <= m_gd;
            m_we    <= a_we;
            m_addr  <= a_addr;
            m_wdata <= a_wdata;
            if (a_addr[1:0] != 2'b00) begin
               m_err   <= 1'b1;
               m_rdata <= '0;
               iss_c   <= -1;
               don_c   <= cyc + 1;
               free_at <= cyc + 2;
            end else begin
               m_err   <= 1'b0;
               m_rdata <= a_we ? '0 : refm[a_addr[7:2]];
               if (a_we) refm[a_addr[7:2]] <= a_wdata;
               iss_c   <= cyc + 1;
               don_c   <= cyc + 2 + L;
               free_at <= cyc + 3 + L;
            end
         end
      end

      // Every-cycle comparison of all outputs against the reference
      initial begin : chkr
         string p;
         logic  dn;
         p = (L == 1) ? "L1" : "L3";
         forever begin
            @(negedge clk);
            if (rst) begin
               chk({p, "_rst_ctl"},
                   {26'b0, cpu_gnt[g], cpu_done[g], cpu_err[g],
                    dbg_gnt[g], dbg_done[g], dbg_err[g]}, '0);
               chk({p, "_rst_mem"}, {30'b0, mem_en[g], mem_we[g]}, '0);
               chk({p, "_rst_maddr"}, mem_addr[g], '0);
               chk({p, "_rst_mwdata"}, mem_wdata[g], '0);
               chk({p, "_rst_crd"}, cpu_rdata[g], '0);
               chk({p, "_rst_drd"}, dbg_rdata[g], '0);
            end else begin
               dn = (cyc == don_c);
               chk({p, "_cpu_gnt"}, 32'(cpu_gnt[g]), 32'(m_gc));
               chk({p, "_dbg_gnt"}, 32'(dbg_gnt[g]), 32'(m_gd));
               chk({p, "_mem_en"}, 32'(mem_en[g]), 32'(cyc == iss_c));
               if (cyc == iss_c) begin
                  chk({p, "_mem_we"}, 32'(mem_we[g]), 32'(m_we));
                  chk({p, "_mem_addr"}, mem_addr[g], m_addr);
                  chk({p, "_mem_wdata"}, mem_wdata[g], m_wdata);
               end
               chk({p, "_cpu_done"}, 32'(cpu_done[g]), 32'(dn && !m_own));
               chk({p, "_dbg_done"}, 32'(dbg_done[g]), 32'(dn && m_own));
               chk({p, "_cpu_err"}, 32'(cpu_err[g]),
                   32'(dn && !m_own && m_err));
               chk({p, "_dbg_err"}, 32'(dbg_err[g]),
                   32'(dn && m_own && m_err));
               chk({p, "_cpu_rdata"}, cpu_rdata[g],
                   (dn && !m_own) ? m_rdata : 32'h0);
               chk({p, "_dbg_rdata"}, dbg_rdata[g],
                   (dn && m_own) ? m_rdata : 32'h0);
            end
         end
      end
   end

   typedef struct {
      logic        dbg;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      int c;
      bit w;
   } ev_t;

   vec_t vt [9];
   ev_t  gq [$];
   ev_t  dq [$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      a = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      return a;
   endfunction

   task automatic run_vec(input vec_t v);
      int          t0;
      int          sd [NI];
      int          se [NI];
      logic        ge [NI];
      logic [31:0] gr [NI];
      logic [31:0] ga [NI];
      logic [31:0] gw [NI];
      step();
      cpu_req = !v.dbg;
      dbg_req = v.dbg;
      if (v.dbg) begin
         dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
      end else begin
         cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
      end
      @(negedge clk);
      t0 = cyc;
      for (int g = 0; g < NI; g++) begin
         chk("vec_gnt", 32'(v.dbg ? dbg_gnt[g] : cpu_gnt[g]), 32'd1);
         sd[g] = -1; se[g] = -1; ge[g] = 1'b0;
         gr[g] = '0; ga[g] = '0; gw[g] = '0;
      end
      for (int k = 1; k <= 7; k++) begin
         step();
         cpu_req = 1'b0;
         dbg_req = 1'b0;
         @(negedge clk);
         for (int g = 0; g < NI; g++) begin
            if (se[g] < 0 && mem_en[g]) begin
               se[g] = cyc; ga[g] = mem_addr[g];
               gw[g] = {31'b0, mem_we[g]};
            end
            if (sd[g] < 0 && (v.dbg ? dbg_done[g] : cpu_done[g])) begin
               sd[g] = cyc;
               ge[g] = v.dbg ? dbg_err[g] : cpu_err[g];
               gr[g] = v.dbg ? dbg_rdata[g] : cpu_rdata[g];
            end
         end
      end
      for (int g = 0; g < NI; g++) begin
         chk("vec_done_cyc", 32'(sd[g] - t0),
             32'(v.err ? 1 : 2 + ((g == 0) ? 1 : 3)));
         chk("vec_err", 32'(ge[g]), 32'(v.err));
         chk("vec_rdata", gr[g], v.rdata);
         chk("vec_mem_en_cyc", 32'(se[g]), 32'(v.err ? -1 : t0 + 1));
         if (!v.err) begin
            chk("vec_mem_addr", ga[g], v.addr);
            chk("vec_mem_we", gw[g], 32'(v.we));
         end
      end
   endtask

   initial begin
      int t0;
      int r;
      int nd;
      int ndg [NI];
      int nen [NI];

      vt[0] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
      vt[1] = '{1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF};
      vt[2] = '{1'b1, 1'b1, 32'h20, 32'h1234, 1'b0, 32'h0};
      vt[3] = '{1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h1234};
      vt[4] = '{1'b0, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0};
      vt[5] = '{1'b0, 1'b0, 32'h14, 32'h0, 1'b0, 32'hC0DE_0005};
      vt[6] = '{1'b1, 1'b1, 32'h22, 32'h7777, 1'b1, 32'h0};
      vt[7] = '{1'b0, 1'b1, 32'h30, 32'h55AA, 1'b0, 32'h0};
      vt[8] = '{1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h55AA};

      rst = 1'b1;
      cpu_req = 1'b1;
      dbg_req = 1'b1;
      step();
      @(negedge clk);
      chk("reset_cpu_gnt", 32'(cpu_gnt[0]), 32'd0);
      chk("reset_dbg_gnt", 32'(dbg_gnt[1]), 32'd0);
      step();
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      step();
      rst = 1'b0;

      foreach (vt[i]) run_vec(vt[i]);

      // Tie from reset release: grants alternate cpu, dbg, ...
      step();
      rst = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h44;
      step();
      step();
      rst = 1'b0;
      r = cyc;
      gq.delete();
      dq.delete();
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         if (cpu_gnt[0]) gq.push_back('{cyc, 1'b0});
         if (dbg_gnt[0]) gq.push_back('{cyc, 1'b1});
         if (cpu_done[0]) dq.push_back('{cyc, 1'b0});
         if (dbg_done[0]) dq.push_back('{cyc, 1'b1});
      end
      chk("tie_gnt_count", 32'(gq.size()), 32'd5);
      chk("tie_done_count", 32'(dq.size()), 32'd4);
      if (gq.size() >= 4 && dq.size() >= 4) begin
         chk("tie_first_gnt_cyc", 32'(gq[0].c), 32'(r));
         for (int i = 0; i < 4; i++) begin
            chk("tie_gnt_who", 32'(gq[i].w), 32'(i % 2));
            chk("tie_gnt_cyc", 32'(gq[i].c), 32'(r + 4 * i));
            chk("tie_done_who", 32'(dq[i].w), 32'(i % 2));
            chk("tie_done_cyc", 32'(dq[i].c), 32'(gq[i].c + 3));
         end
      end
      step();
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      repeat (8) step();

      // Reset asserted while both instances sit in WAIT
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h24;
      @(negedge clk);
      chk("rstw_gnt", 32'(cpu_gnt[1]), 32'd1);
      step();
      cpu_req = 1'b0;
      @(negedge clk);
      chk("rstw_issue_addr", mem_addr[1], 32'h24);
      step();
      rst = 1'b1;
      #1;
      chk("rstw_mem_addr", mem_addr[1], 32'h0);
      chk("rstw_done", {30'b0, cpu_done[1], cpu_done[0]}, 32'h0);
      step();
      step();
      rst = 1'b0;
      nd = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         for (int g = 0; g < NI; g++)
            if (cpu_done[g] || dbg_done[g] || mem_en[g]) nd++;
      end
      chk("rstw_no_done", 32'(nd), 32'd0);
      step();
      cpu_req = 1'b1; cpu_addr = 32'h24;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h28;
      @(negedge clk);
      chk("rstw_tie_cpu_l3", 32'(cpu_gnt[1]), 32'd1);
      chk("rstw_tie_dbg_l3", 32'(dbg_gnt[1]), 32'd0);
      chk("rstw_tie_cpu_l1", 32'(cpu_gnt[0]), 32'd1);
      step();
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      repeat (8) step();

      // Debug request raised and withdrawn while cpu access in flight
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2C;
      @(negedge clk);
      t0 = cyc;
      for (int g = 0; g < NI; g++) begin
         ndg[g] = 0;
         nen[g] = 0;
      end
      for (int k = 1; k <= 9; k++) begin
         step();
         if (k == 1) cpu_req = 1'b0;
         if (k == 2) begin
            dbg_req = 1'b1; dbg_we = 1'b1;
            dbg_addr = 32'h30; dbg_wdata = 32'hBADBAD00;
         end
         if (k == 3) dbg_req = 1'b0;
         @(negedge clk);
         for (int g = 0; g < NI; g++) begin
            if (dbg_gnt[g]) ndg[g]++;
            if (mem_en[g]) nen[g]++;
         end
      end
      for (int g = 0; g < NI; g++) begin
         chk("wd_dbg_gnt", 32'(ndg[g]), 32'd0);
         chk("wd_mem_en", 32'(nen[g]), 32'd1);
      end
      chk("wd_span", 32'(cyc - t0), 32'd9);

      // Random traffic, checked every cycle by the reference
      for (int k = 0; k < 3000; k++) begin
         step();
         if (cpu_req) begin
            if ($urandom_range(0, 7) == 0) cpu_req = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            cpu_req = 1'b1;
            cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = rnd_addr();
            cpu_wdata = $urandom;
         end
         if (dbg_req) begin
            if ($urandom_range(0, 7) == 0) dbg_req = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            dbg_req = 1'b1;
            dbg_we = 1'($urandom_range(0, 1));
            dbg_addr = rnd_addr();
            dbg_wdata = $urandom;
         end
      end
      step();
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      repeat (8) step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
